// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline register with data-memory access sequencer.
// Latches execute results, holds the cache request until dhit, and stalls upstream while busy.
module exmem_stage_reg #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] npc_ex,
    input  logic [WORD_W-1:0] rdat1_ex,
    input  logic [WORD_W-1:0] rdat2_ex,
    input  logic [WORD_W-1:0] imm_ex,
    input  logic [WORD_W-1:0] aluOut_ex,
    input  logic              rwen_ex,
    input  logic              memregSel_ex,
    input  logic [REG_AW-1:0] wSel_ex,
    input  logic              dren_ex,
    input  logic              dwen_ex,
    input  logic              halt_ex,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] npc_exmem,
    output logic [WORD_W-1:0] rdat1_exmem,
    output logic [WORD_W-1:0] imm_exmem,
    output logic [WORD_W-1:0] portOut_exmem,
    output logic [WORD_W-1:0] dload_exmem,
    output logic              rwen_exmem,
    output logic              memregSel_exmem,
    output logic [REG_AW-1:0] wSel_exmem,
    output logic              valid_exmem,
    output logic              halt_exmem,
    output logic              mem_stall,
    output logic              mem_timeout
);

    localparam int unsigned CntW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_LIMIT);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e state_q, state_d;

    logic [WORD_W-1:0] npc_q, npc_d;
    logic [WORD_W-1:0] rdat1_q, rdat1_d;
    logic [WORD_W-1:0] rdat2_q, rdat2_d;
    logic [WORD_W-1:0] imm_q, imm_d;
    logic [WORD_W-1:0] port_q, port_d;
    logic [WORD_W-1:0] dload_q, dload_d;
    logic              rwen_q, rwen_d;
    logic              memreg_q, memreg_d;
    logic [REG_AW-1:0] wsel_q, wsel_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic              halt_q, halt_d;
    logic              valid_q, valid_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic in_idle;
    logic in_access;
    logic capture;
    logic bubble;

    assign in_idle   = (state_q == StIdle);
    assign in_access = (state_q == StAccess);
    // Flush wins over ihit; neither has any effect while an access is in flight.
    assign capture   = in_idle && ihit && !flush;
    assign bubble    = in_idle && flush;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (capture && ex_valid && (dren_ex || dwen_ex)) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (dhit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pipeline register next-state
    always_comb begin
        npc_d    = npc_q;
        rdat1_d  = rdat1_q;
        rdat2_d  = rdat2_q;
        imm_d    = imm_q;
        port_d   = port_q;
        dload_d  = dload_q;
        rwen_d   = rwen_q;
        memreg_d = memreg_q;
        wsel_d   = wsel_q;
        dren_d   = dren_q;
        dwen_d   = dwen_q;
        halt_d   = halt_q;
        valid_d  = valid_q;

        if (capture) begin
            npc_d    = npc_ex;
            rdat1_d  = rdat1_ex;
            rdat2_d  = rdat2_ex;
            imm_d    = imm_ex;
            port_d   = aluOut_ex;
            rwen_d   = rwen_ex;
            memreg_d = memregSel_ex;
            wsel_d   = wSel_ex;
            dren_d   = dren_ex;
            dwen_d   = dwen_ex;
            valid_d  = ex_valid;
            halt_d   = halt_q | halt_ex;
        end else if (bubble) begin
            // Data fields hold; only the controls that could cause side effects are killed.
            valid_d = 1'b0;
            rwen_d  = 1'b0;
            dren_d  = 1'b0;
            dwen_d  = 1'b0;
        end

        if (in_access && dhit && dren_q) begin
            dload_d = dmemload;
        end
    end

    // Wait counter and sticky timeout
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (in_access && !dhit) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == CntMax) begin
                timeout_d = 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            npc_q     <= '0;
            rdat1_q   <= '0;
            rdat2_q   <= '0;
            imm_q     <= '0;
            port_q    <= '0;
            dload_q   <= '0;
            rwen_q    <= 1'b0;
            memreg_q  <= 1'b0;
            wsel_q    <= '0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            halt_q    <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            npc_q     <= npc_d;
            rdat1_q   <= rdat1_d;
            rdat2_q   <= rdat2_d;
            imm_q     <= imm_d;
            port_q    <= port_d;
            dload_q   <= dload_d;
            rwen_q    <= rwen_d;
            memreg_q  <= memreg_d;
            wsel_q    <= wsel_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            halt_q    <= halt_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Output logic
    always_comb begin
        dmemREN         = in_access & dren_q;
        dmemWEN         = in_access & dwen_q;
        dmemaddr        = in_access ? port_q : '0;
        dmemstore       = in_access ? rdat2_q : '0;
        mem_stall       = in_access;
        npc_exmem       = npc_q;
        rdat1_exmem     = rdat1_q;
        imm_exmem       = imm_q;
        portOut_exmem   = port_q;
        dload_exmem     = dload_q;
        rwen_exmem      = rwen_q;
        memregSel_exmem = memreg_q;
        wSel_exmem      = wsel_q;
        valid_exmem     = valid_q;
        halt_exmem      = halt_q;
        mem_timeout     = timeout_q;
    end

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Directed bench for exmem_stage_reg: behavioural model checked every cycle plus literal pins.
module tb_exmem_stage_reg;

    localparam int unsigned W   = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned LIM = 4;

    logic          CLK, nRST, ihit, flush, ex_valid;
    logic [W-1:0]  npc_ex, rdat1_ex, rdat2_ex, imm_ex, aluOut_ex, dmemload;
    logic          rwen_ex, memregSel_ex, dren_ex, dwen_ex, halt_ex, dhit;
    logic [AW-1:0] wSel_ex;

    logic          dmemREN, dmemWEN, rwen_exmem, memregSel_exmem, valid_exmem;
    logic          halt_exmem, mem_stall, mem_timeout;
    logic [W-1:0]  dmemaddr, dmemstore, npc_exmem, rdat1_exmem, imm_exmem;
    logic [W-1:0]  portOut_exmem, dload_exmem;
    logic [AW-1:0] wSel_exmem;

    exmem_stage_reg #(.WORD_W(W), .REG_AW(AW), .WAIT_LIMIT(LIM)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .ex_valid(ex_valid),
        .npc_ex(npc_ex), .rdat1_ex(rdat1_ex), .rdat2_ex(rdat2_ex), .imm_ex(imm_ex),
        .aluOut_ex(aluOut_ex), .rwen_ex(rwen_ex), .memregSel_ex(memregSel_ex),
        .wSel_ex(wSel_ex), .dren_ex(dren_ex), .dwen_ex(dwen_ex), .halt_ex(halt_ex),
        .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .npc_exmem(npc_exmem),
        .rdat1_exmem(rdat1_exmem), .imm_exmem(imm_exmem), .portOut_exmem(portOut_exmem),
        .dload_exmem(dload_exmem), .rwen_exmem(rwen_exmem),
        .memregSel_exmem(memregSel_exmem), .wSel_exmem(wSel_exmem),
        .valid_exmem(valid_exmem), .halt_exmem(halt_exmem), .mem_stall(mem_stall),
        .mem_timeout(mem_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is either free (accepting) or busy with one memory op.
    bit           m_busy, m_valid, m_rwen, m_memreg, m_dren, m_dwen, m_halt, m_timeout;
    logic [W-1:0] m_npc, m_rdat1, m_rdat2, m_imm, m_port, m_dload;
    logic [AW-1:0] m_wsel;
    int           m_waited;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy <= 0; m_valid <= 0; m_rwen <= 0; m_memreg <= 0; m_dren <= 0; m_dwen <= 0;
            m_halt <= 0; m_timeout <= 0; m_npc <= 0; m_rdat1 <= 0; m_rdat2 <= 0;
            m_imm <= 0; m_port <= 0; m_dload <= 0; m_wsel <= 0; m_waited <= 0;
        end else if (!m_busy) begin
            if (flush) begin
                m_valid <= 0; m_rwen <= 0; m_dren <= 0; m_dwen <= 0;
            end else if (ihit) begin
                m_npc <= npc_ex; m_rdat1 <= rdat1_ex; m_rdat2 <= rdat2_ex; m_imm <= imm_ex;
                m_port <= aluOut_ex; m_rwen <= rwen_ex; m_memreg <= memregSel_ex;
                m_wsel <= wSel_ex; m_dren <= dren_ex; m_dwen <= dwen_ex; m_valid <= ex_valid;
                if (halt_ex) m_halt <= 1;
                m_busy <= ex_valid && (dren_ex || dwen_ex);
                m_waited <= 0;
            end
        end else if (dhit) begin
            if (m_dren) m_dload <= dmemload;
            m_busy   <= 0;
            m_waited <= 0;
        end else begin
            if (m_waited < LIM) m_waited <= m_waited + 1;
            if (m_waited + 1 >= LIM) m_timeout <= 1;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("m_ren",     32'(dmemREN),     32'(m_busy && m_dren));
            check("m_wen",     32'(dmemWEN),     32'(m_busy && m_dwen));
            check("m_addr",    dmemaddr,         m_busy ? m_port : 32'h0);
            check("m_store",   dmemstore,        m_busy ? m_rdat2 : 32'h0);
            check("m_stall",   32'(mem_stall),   32'(m_busy));
            check("m_npc",     npc_exmem,        m_npc);
            check("m_rdat1",   rdat1_exmem,      m_rdat1);
            check("m_imm",     imm_exmem,        m_imm);
            check("m_port",    portOut_exmem,    m_port);
            check("m_dload",   dload_exmem,      m_dload);
            check("m_rwen",    32'(rwen_exmem),  32'(m_rwen));
            check("m_memreg",  32'(memregSel_exmem), 32'(m_memreg));
            check("m_wsel",    32'(wSel_exmem),  32'(m_wsel));
            check("m_valid",   32'(valid_exmem), 32'(m_valid));
            check("m_halt",    32'(halt_exmem),  32'(m_halt));
            check("m_timeout", 32'(mem_timeout), 32'(m_timeout));
        end
    end

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    int ren_cycles;

    initial begin
        nRST = 1; ihit = 0; flush = 0; ex_valid = 0; npc_ex = 0; rdat1_ex = 0; rdat2_ex = 0;
        imm_ex = 0; aluOut_ex = 0; rwen_ex = 0; memregSel_ex = 0; wSel_ex = 0; dren_ex = 0;
        dwen_ex = 0; halt_ex = 0; dhit = 0; dmemload = 0;
        #1 nRST = 0;
        chk_en = 1;
        step(); step();
        check("rst_valid",   32'(valid_exmem), 32'h0);
        check("rst_stall",   32'(mem_stall),   32'h0);
        check("rst_ren",     32'(dmemREN),     32'h0);
        check("rst_timeout", 32'(mem_timeout), 32'h0);
        check("rst_port",    portOut_exmem,    32'h0);
        nRST = 1;
        step();

        // ALU pass-through
        ihit = 1; ex_valid = 1; aluOut_ex = 32'h10; wSel_ex = 5; rwen_ex = 1;
        npc_ex = 32'h44; rdat1_ex = 32'h11; imm_ex = 32'h22;
        step();
        check("alu_port",  portOut_exmem,    32'h10);
        check("alu_wsel",  32'(wSel_exmem),  32'h5);
        check("alu_valid", 32'(valid_exmem), 32'h1);
        check("alu_stall", 32'(mem_stall),   32'h0);
        check("alu_ren",   32'(dmemREN),     32'h0);
        check("alu_npc",   npc_exmem,        32'h44);
        ihit = 0; ex_valid = 0;
        step();

        // Load, dhit on third ACCESS cycle
        ihit = 1; ex_valid = 1; dren_ex = 1; aluOut_ex = 32'h100; wSel_ex = 7; memregSel_ex = 1;
        step();
        ren_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmemREN === 1'b1) ren_cycles++;
            if (i == 0) begin
                check("ld_addr",  dmemaddr,        32'h100);
                check("ld_stall", 32'(mem_stall),  32'h1);
                aluOut_ex = 32'h999;
            end
            if (i == 2) begin
                dhit = 1; dmemload = 32'hDEADBEEF;
            end
            step();
        end
        dhit = 0; ihit = 0; ex_valid = 0; dren_ex = 0; memregSel_ex = 0;
        check("ld_cycles",   32'(ren_cycles),  32'h3);
        check("ld_ren_off",  32'(dmemREN),     32'h0);
        check("ld_stall_off", 32'(mem_stall),  32'h0);
        check("ld_dload",    dload_exmem,      32'hDEADBEEF);
        check("ld_frozen",   portOut_exmem,    32'h100);

        // Store, dhit in first ACCESS cycle
        ihit = 1; ex_valid = 1; dwen_ex = 1; rdat2_ex = 32'hCAFE0001; aluOut_ex = 32'h204;
        step();
        check("st_wen",   32'(dmemWEN), 32'h1);
        check("st_ren",   32'(dmemREN), 32'h0);
        check("st_store", dmemstore,    32'hCAFE0001);
        check("st_addr",  dmemaddr,     32'h204);
        dhit = 1; ihit = 0; ex_valid = 0; dwen_ex = 0;
        step();
        dhit = 0;
        check("st_wen_off", 32'(dmemWEN), 32'h0);
        check("st_dload",   dload_exmem,  32'hDEADBEEF);

        // Flush beats ihit
        ihit = 1; flush = 1; ex_valid = 1; dren_ex = 1; rwen_ex = 1; aluOut_ex = 32'h300;
        step();
        flush = 0; ihit = 0;
        check("fl_valid", 32'(valid_exmem), 32'h0);
        check("fl_rwen",  32'(rwen_exmem),  32'h0);
        check("fl_stall", 32'(mem_stall),   32'h0);
        check("fl_hold",  portOut_exmem,    32'h204);
        step();
        check("fl_noacc", 32'(dmemREN), 32'h0);

        // Flush during ACCESS is ignored
        ihit = 1; ex_valid = 1; dren_ex = 1; aluOut_ex = 32'h400;
        step();
        flush = 1;
        step();
        check("fa_ren",   32'(dmemREN),     32'h1);
        check("fa_addr",  dmemaddr,         32'h400);
        check("fa_valid", 32'(valid_exmem), 32'h1);
        dhit = 1;
        step();
        dhit = 0; flush = 0; ihit = 0;
        check("fa_done",  32'(mem_stall),   32'h0);
        check("fa_kept",  32'(valid_exmem), 32'h1);

        // Timeout after LIM ACCESS cycles, request held
        ihit = 1; ex_valid = 1; dren_ex = 1; aluOut_ex = 32'h500; dmemload = 32'h0BADF00D;
        step();
        ihit = 0;
        for (int i = 0; i < 4; i++) begin
            check("to_early", 32'(mem_timeout), 32'h0);
            check("to_ren",   32'(dmemREN),     32'h1);
            step();
        end
        check("to_set", 32'(mem_timeout), 32'h1);
        check("to_req", 32'(dmemREN),     32'h1);
        step(); step();
        check("to_hold", 32'(dmemREN), 32'h1);
        dhit = 1;
        step();
        dhit = 0;
        check("to_idle",   32'(mem_stall),   32'h0);
        check("to_sticky", 32'(mem_timeout), 32'h1);
        check("to_dload",  dload_exmem,      32'h0BADF00D);

        // Sticky halt survives a later capture and a flush
        ihit = 1; ex_valid = 1; dren_ex = 0; halt_ex = 1;
        step();
        halt_ex = 0;
        step();
        check("halt_keep", 32'(halt_exmem), 32'h1);
        flush = 1;
        step();
        flush = 0; ihit = 0;
        check("halt_flush", 32'(halt_exmem), 32'h1);

        // Async reset mid-ACCESS
        ihit = 1; ex_valid = 1; dren_ex = 1; aluOut_ex = 32'h600;
        step();
        ihit = 0; ex_valid = 0; dren_ex = 0;
        #1 check("ar_pre", 32'(dmemREN), 32'h1);
        #1 nRST = 0;
        #1;
        check("ar_ren",     32'(dmemREN),     32'h0);
        check("ar_stall",   32'(mem_stall),   32'h0);
        check("ar_valid",   32'(valid_exmem), 32'h0);
        check("ar_timeout", 32'(mem_timeout), 32'h0);
        check("ar_halt",    32'(halt_exmem),  32'h0);
        step();
        nRST = 1;
        step();
        check("ar_idle", 32'(mem_stall), 32'h0);

        ihit = 1; ex_valid = 1; rwen_ex = 1; aluOut_ex = 32'h77; wSel_ex = 3;
        step();
        check("post_port",  portOut_exmem,    32'h77);
        check("post_valid", 32'(valid_exmem), 32'h1);
        check("post_stall", 32'(mem_stall),   32'h0);
        ihit = 0; ex_valid = 0;
        step();

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
